// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button synchronizers and debouncers, run/lap/stop/clear FSM, lap-freeze display mux.
// Optional max-count hold at 5999 is enabled by defining STOPWATCH_AUTO_STOP_EN.
module stopwatch_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter int          CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] cnt_left,
  input  logic [3:0] cnt_middle_left,
  input  logic [3:0] cnt_middle_right,
  input  logic [3:0] cnt_right,
  output logic       timer_go,
  output logic       timer_reset,
  output logic [3:0] disp_left,
  output logic [3:0] disp_middle_left,
  output logic [3:0] disp_middle_right,
  output logic [3:0] disp_right,
  output logic       running,
  output logic       lap_active
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RUN     = 3'd1;
  localparam logic [2:0] LAP     = 3'd2;
  localparam logic [2:0] STOPPED = 3'd3;
  localparam logic [2:0] CLEAR   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 20'd1);

  // Index 0 is start/stop, index 1 is lap/reset.
  logic [1:0]       sync1_q, sync2_q, deb_q, press_q;
  logic [CNT_W-1:0] cnt_q [2];

  logic [2:0]  state_q, state_d;
  logic        snap_load;
  logic [15:0] snap_q;
  logic        timer_go_q, timer_reset_q, lap_active_q;
  logic        at_max;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {btn_lr, btn_ss};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            deb_q[i]   <= sync2_q[i];
            cnt_q[i]   <= '0;
            press_q[i] <= sync2_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

`ifdef STOPWATCH_AUTO_STOP_EN
  assign at_max = timer_go_q && (cnt_right == 4'd5) && (cnt_middle_right == 4'd9) &&
                  (cnt_middle_left == 4'd9) && (cnt_left == 4'd9);
`else
  assign at_max = 1'b0;
`endif

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    snap_load = 1'b0;
    case (state_q)
      IDLE:    if (press_q[0]) state_d = RUN;
      RUN: begin
        if (press_q[0]) begin
          state_d = STOPPED;
        end else if (press_q[1]) begin
          state_d   = LAP;
          snap_load = 1'b1;
        end
      end
      LAP: begin
        if (press_q[0])      state_d = STOPPED;
        else if (press_q[1]) state_d = RUN;
      end
      STOPPED: begin
        if (press_q[0])      state_d = RUN;
        else if (press_q[1]) state_d = CLEAR;
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Max-count hold overrides any button press seen in the same cycle.
    if (at_max && (state_q == RUN || state_q == LAP)) begin
      state_d   = STOPPED;
      snap_load = 1'b0;
    end
  end

  // NOTE: the snapshot is a plain register bank, so it takes the async reset like every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      snap_q        <= '0;
      timer_go_q    <= 1'b0;
      timer_reset_q <= 1'b0;
      lap_active_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_go_q    <= (state_d == RUN) || (state_d == LAP);
      timer_reset_q <= (state_d == CLEAR);
      lap_active_q  <= (state_d == LAP);
      if (snap_load) snap_q <= {cnt_right, cnt_middle_right, cnt_middle_left, cnt_left};
    end
  end

  assign timer_go    = timer_go_q;
  assign timer_reset = timer_reset_q;
  assign running     = timer_go_q;
  assign lap_active  = lap_active_q;

  assign {disp_right, disp_middle_right, disp_middle_left, disp_left} = lap_active_q ? snap_q :
         {cnt_right, cnt_middle_right, cnt_middle_left, cnt_left};

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4 (press pulse 6 edges after a button edge).
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss = 1'b0, btn_lr = 1'b0;
  logic [3:0] cnt_left = '0, cnt_middle_left = '0, cnt_middle_right = '0, cnt_right = '0;
  logic       timer_go, timer_reset, running, lap_active;
  logic [3:0] disp_left, disp_middle_left, disp_middle_right, disp_right;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(20'd4), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .cnt_left(cnt_left), .cnt_middle_left(cnt_middle_left),
    .cnt_middle_right(cnt_middle_right), .cnt_right(cnt_right),
    .timer_go(timer_go), .timer_reset(timer_reset),
    .disp_left(disp_left), .disp_middle_left(disp_middle_left),
    .disp_middle_right(disp_middle_right), .disp_right(disp_right),
    .running(running), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input logic [15:0] v);
    {cnt_right, cnt_middle_right, cnt_middle_left, cnt_left} = v;
  endtask

  function automatic logic [15:0] disp_word();
    return {disp_right, disp_middle_right, disp_middle_left, disp_left};
  endfunction

  function automatic logic [3:0] ctrl_word();
    return {timer_go, timer_reset, running, lap_active};
  endfunction

  task automatic do_reset();
    reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Press for 7 edges (state updates on the 7th), release and let the release settle.
  task automatic press_btn(input logic ss, input logic lr);
    btn_ss = ss; btn_lr = lr;
    step(7);
    btn_ss = 1'b0; btn_lr = 1'b0;
    step(7);
  endtask

  initial begin
    // Reset state; ctrl_word = {go, reset, running, lap}
    set_cnt(16'h4321);
    step(2);
    check("rst_ctrl", 16'(ctrl_word()), 16'h0);
    check("rst_disp_live", disp_word(), 16'h4321);
    do_reset();

    // Glitch of 3 cycles must not produce a press
    btn_ss = 1'b1; step(3); btn_ss = 1'b0; step(10);
    check("glitch_go", 16'(timer_go), 16'h0);
    check("glitch_running", 16'(running), 16'h0);

    // Held press: timer_go rises on edge 7 after the raw edge
    btn_ss = 1'b1;
    step(6);
    check("ss_go_edge6", 16'(timer_go), 16'h0);
    step(1);
    check("ss_go_edge7", 16'(timer_go), 16'h1);
    check("ss_running", 16'(running), 16'h1);
    step(3); btn_ss = 1'b0; step(10);
    check("ss_single_press", 16'(ctrl_word()), 16'b1010);

    // Lap freeze
    do_reset();
    set_cnt(16'h1230);
    press_btn(1'b1, 1'b0);
    btn_lr = 1'b1; step(7);
    check("lap_ctrl", 16'(ctrl_word()), 16'b1011);
    check("lap_disp_snap", disp_word(), 16'h1230);
    set_cnt(16'h0040);
    step(1);
    check("lap_disp_hold", disp_word(), 16'h1230);
    check("lap_go_kept", 16'(timer_go), 16'h1);
    btn_lr = 1'b0; step(7);
    press_btn(1'b0, 1'b1);
    check("unlap_ctrl", 16'(ctrl_word()), 16'b1010);
    check("unlap_disp_live", disp_word(), 16'h0040);

    // Stop then clear pulse, then lr ignored in IDLE
    press_btn(1'b1, 1'b0);
    check("stop_ctrl", 16'(ctrl_word()), 16'h0);
    btn_lr = 1'b1;
    step(6);
    check("clr_before", 16'(ctrl_word()), 16'h0);
    step(1);
    check("clr_pulse", 16'(ctrl_word()), 16'b0100);
    step(1);
    check("clr_done", 16'(ctrl_word()), 16'h0);
    btn_lr = 1'b0; step(7);
    press_btn(1'b0, 1'b1);
    check("idle_lr_ignored", 16'(ctrl_word()), 16'h0);
    press_btn(1'b1, 1'b0);
    check("idle_to_run", 16'(ctrl_word()), 16'b1010);

    // Simultaneous ss+lr in RUN: ss wins -> STOPPED (lr then clears)
    do_reset();
    press_btn(1'b1, 1'b0);
    press_btn(1'b1, 1'b1);
    check("simul_ctrl", 16'(ctrl_word()), 16'h0);
    btn_lr = 1'b1; step(7);
    check("simul_was_stopped", 16'(ctrl_word()), 16'b0100);
    btn_lr = 1'b0; step(7);

    // Asynchronous reset while in LAP
    do_reset();
    set_cnt(16'h4321);
    press_btn(1'b1, 1'b0);
    press_btn(1'b0, 1'b1);
    check("pre_rst_lap", 16'(ctrl_word()), 16'b1011);
    set_cnt(16'h5678);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ctrl", 16'(ctrl_word()), 16'h0);
    check("async_rst_disp", disp_word(), 16'h5678);
    step(1);
    reset = 1'b0;
    step(2);
    check("post_rst_idle", 16'(ctrl_word()), 16'h0);

    // Max count 5999 in RUN
    set_cnt(16'h5999);
    btn_ss = 1'b1; step(7);
    check("max_run", 16'(timer_go), 16'h1);
    step(1);
`ifdef STOPWATCH_AUTO_STOP_EN
    check("max_autostop", 16'(ctrl_word()), 16'h0);
    check("max_disp", disp_word(), 16'h5999);
`else
    check("max_no_stop", 16'(ctrl_word()), 16'b1010);
`endif
    btn_ss = 1'b0; step(7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the four-digit stopwatch counter datapath.
- Synchronizes and debounces two raw push-buttons: start/stop and lap/reset.
- Drives the counter's go/reset controls.
- Provides a lap-freeze display path. It presents either the live digits or a latched snapshot to the seven-segment driver.

Parameters:
- DEBOUNCE_CYCLES, 20'd500000: consecutive stable cycles required before a button level is accepted; range 2..2^20-1.
- CNT_W, 20: width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_ss  input  1  raw start/stop button, asynchronous to clk
- btn_lr  input  1  raw lap/reset button, asynchronous to clk
- cnt_left  input  4  live counter digit 0 (least significant, 0-9)
- cnt_middle_left  input  4  live digit 1 (0-9)
- cnt_middle_right  input  4  live digit 2 (0-9)
- cnt_right  input  4  live digit 3 (most significant, 0-5)
- timer_go  output  1  enable to counter
- timer_reset  output  1  clear request to counter
- disp_left, disp_middle_left, disp_middle_right, disp_right  output  4 each  digits to display
- running  output  1  high in RUN or LAP
- lap_active  output  1  high in LAP

Behaviour:
Reset:
- On reset, all flops clear asynchronously and the state becomes IDLE.
- timer_go=0, timer_reset=0, running=0, lap_active=0.
- Lap snapshot = 0; disp_* follow the live cnt_* values.

Input conditioning (per button):
- 2-flop synchronizer, then a debounce counter.
- When the synchronized level differs from the debounced level, the counter increments; otherwise it clears.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value and the counter clears.
- A press pulse (1 cycle) fires on the debounced 0->1 edge only. Release generates nothing.
- Latency from a stable raw edge to the press pulse is DEBOUNCE_CYCLES+2 cycles.

FSM states (registered): IDLE, RUN, LAP, STOPPED, CLEAR.
- IDLE: ss press -> RUN; lr press ignored.
- RUN: ss -> STOPPED; lr -> LAP, and the snapshot latches cnt_* in the same cycle.
- LAP: ss -> STOPPED and the snapshot is released; lr -> RUN and the snapshot is released.
- STOPPED: ss -> RUN; lr -> CLEAR.
- CLEAR: unconditional -> IDLE after exactly 1 cycle. Button presses arriving in CLEAR are dropped.
- Simultaneous ss and lr press pulses in the same cycle: ss wins, lr is discarded.

Outputs (all registered, decoded from the state register):
- timer_go=1 in RUN and LAP, else 0.
- timer_reset=1 only in CLEAR; timer_go is 0 there, so the counter sees a clear with go low.
- disp_* = snapshot when in LAP, else cnt_*.
- The counter keeps running throughout LAP.

Reset mid-operation (any state, including LAP or CLEAR): immediate return to IDLE. Snapshot and debounce state are discarded.

Optional Feature:
Macro: STOPWATCH_AUTO_STOP_EN
- Defined: in RUN or LAP, when the live digits read 5,9,9,9 (right..left) while timer_go=1, the FSM goes to STOPPED next cycle and any lap is released. This is the max-count hold: the display stays at 5999. The condition has priority over button presses in that cycle.
- Undefined: no compare logic; the counter wraps to 0000 and the FSM stays in RUN/LAP.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then hold btn_ss high 10 cycles -> exactly one press; timer_go rises at cycle 7 after the edge (4+2 debounce, +1 state); running=1.
2. btn_ss glitch high for 3 cycles, then low -> no press; state stays IDLE, timer_go=0.
3. RUN with cnt_* = 0,3,2,1; press lr -> lap_active=1, disp_* hold 0,3,2,1 while cnt_* advances to 0,4,0,0; press lr again -> disp_* track live 0,4,0,0.
4. RUN -> ss (STOPPED) -> lr -> timer_reset high exactly 1 cycle with timer_go=0, then IDLE; a second lr press in IDLE -> no output change.
5. RUN, ss and lr press pulses in the same cycle -> STOPPED; lap_active stays 0.
6. Assert reset while in LAP -> all outputs at reset values within the same cycle (asynchronous); with STOPWATCH_AUTO_STOP_EN, live digits 5,9,9,9 in RUN -> STOPPED next cycle and timer_go=0.
